// File: rtl/fetch_decode.sv
// fetch_decode: instruction fetch + decode stage in front of the CPU control FSM.
//
// Owns the program counter and the instruction register (IR). A fetch runs a
// request/valid handshake to instruction memory with any latency of one cycle
// or more. The IR is decoded combinationally into opcode, is_alu_operation and
// operand fields. The PC advances on next_, either sequentially or by a
// conditional branch (BEQ/BNE) whose 4-bit signed offset is carried in rd.
//
// Ports:
//   clock, reset_n      clock, synchronous active-low reset
//   fetch_, next_       control strobes: start a fetch / advance the PC
//   halt_               CPU halted; the block parks in HALTED until reset
//   branch_cond         rs1==rs2 compare result, sampled with next_
//   imem_req/imem_addr  read request pulse and address (held until data returns)
//   imem_valid/rdata    read data return
//   fetch_busy          fetch in flight; the control FSM stalls on it
//   opcode..imm, pc     decoded IR fields and current PC
//   proto_err           sticky protocol-violation flag
//
// Optional build macro FETCH_DECODE_INSTR_COUNT_EN adds retired_count[15:0],
// a saturating count of accepted next_ strobes.
module fetch_decode #(
  parameter int ADDR_WIDTH   = 8,
  parameter int INSTR_WIDTH  = 16,
  parameter int OPCODE_SIZE  = 4,
  parameter int ALU_OP_COUNT = 8,
  parameter int BEQ_OP       = 12,
  parameter int BNE_OP       = 13,
  parameter int HALT_OP      = 15
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   fetch_,
  input  logic                   next_,
  input  logic                   halt_,
  input  logic                   branch_cond,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   fetch_busy,
  output logic [OPCODE_SIZE-1:0] opcode,
  output logic                   is_alu_operation,
  output logic [3:0]             rd,
  output logic [3:0]             rs1,
  output logic [3:0]             rs2,
  output logic [7:0]             imm,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   proto_err
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  ,
  output logic [15:0]            retired_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HALTED} state_e;

  localparam logic [OPCODE_SIZE-1:0] BEQ  = OPCODE_SIZE'(BEQ_OP);
  localparam logic [OPCODE_SIZE-1:0] BNE  = OPCODE_SIZE'(BNE_OP);
  localparam logic [OPCODE_SIZE-1:0] HALT = OPCODE_SIZE'(HALT_OP);
  // One extra bit so ALU_OP_COUNT == 2^OPCODE_SIZE still compares correctly.
  localparam logic [OPCODE_SIZE:0]   ALU_LIM = (OPCODE_SIZE+1)'(ALU_OP_COUNT);

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   err_q, err_d;
  logic                   busy_st, fetch_ok, next_ok, taken;
  logic [ADDR_WIDTH-1:0]  br_off;

  // Decode
  assign opcode           = ir_q[INSTR_WIDTH-1 -: OPCODE_SIZE];
  assign rd               = ir_q[11:8];
  assign rs1              = ir_q[7:4];
  assign rs2              = ir_q[3:0];
  assign imm              = ir_q[7:0];
  assign is_alu_operation = ({1'b0, opcode} < ALU_LIM);

  // Branch offset is rd, sign-extended; PC arithmetic wraps naturally.
  assign br_off = {{(ADDR_WIDTH-4){rd[3]}}, rd};
  assign taken  = ((opcode == BEQ) && branch_cond) || ((opcode == BNE) && !branch_cond);

  // Registered busy (REQ/WAIT) is what the protocol checks use; the output
  // additionally covers the accept cycle so the control FSM stalls at once.
  assign busy_st    = (state_q == S_REQ) || (state_q == S_WAIT);
  assign fetch_busy = busy_st || fetch_ok;
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = addr_q;
  assign pc         = pc_q;
  assign proto_err  = err_q;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    ir_d     = ir_q;
    err_d    = err_q;
    fetch_ok = 1'b0;
    next_ok  = 1'b0;

    if ((fetch_ && (busy_st || state_q == S_HALTED)) ||
        (next_ && busy_st) || (fetch_ && next_))
      err_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (halt_) begin
          state_d = S_HALTED;
        end else if (fetch_ && !next_) begin
          fetch_ok = 1'b1;
          addr_d   = pc_q;
          state_d  = S_REQ;
        end else if (next_ && !fetch_) begin
          next_ok = 1'b1;
          pc_d    = pc_q + (taken ? br_off : ADDR_WIDTH'(1));
        end
      end
      // Data is never sampled in REQ, even if imem_valid is already high.
      S_REQ:  state_d = halt_ ? S_HALTED : S_WAIT;
      S_WAIT: begin
        if (halt_) begin
          state_d = S_HALTED;
        end else if (imem_valid) begin
          ir_d    = imem_rdata;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_HALTED;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      ir_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      err_q   <= err_d;
    end
  end

`ifdef FETCH_DECODE_INSTR_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // next_ is only accepted in IDLE, so the count is frozen in HALTED.
  always_comb begin
    cnt_d = cnt_q;
    if (next_ok && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign retired_count = cnt_q;
`endif

  // HALT_OP is an encoding owned by the control FSM; it has no local effect.
  logic halt_op_unused;
  assign halt_op_unused = (opcode == HALT);

endmodule

// File: tb/tb_fetch_decode.sv
module tb_fetch_decode;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetch_ = 1'b0, next_ = 1'b0, halt_ = 1'b0, branch_cond = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        fetch_busy;
  logic [3:0]  opcode, rd, rs1, rs2;
  logic        is_alu_operation;
  logic [7:0]  imm, pc;
  logic        proto_err;
`ifdef FETCH_DECODE_INSTR_COUNT_EN
  logic [15:0] retired_count;
`endif

  fetch_decode dut (
    .clock(clock), .reset_n(reset_n), .fetch_(fetch_), .next_(next_), .halt_(halt_),
    .branch_cond(branch_cond), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .fetch_busy(fetch_busy),
    .opcode(opcode), .is_alu_operation(is_alu_operation), .rd(rd), .rs1(rs1),
    .rs2(rs2), .imm(imm), .pc(pc), .proto_err(proto_err)
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    , .retired_count(retired_count)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no matching expectation (cycle %0d)", name, cyc);
  endtask

  // Reference model state
  typedef struct {
    logic [15:0] ir;
    logic [7:0]  pc;
    logic        err;
    int          cyc;
  } exp_t;

  logic [7:0]  m_pc = 8'd0;
  logic [15:0] m_ir = 16'd0;
  logic        m_err = 1'b0;
  logic        m_halted = 1'b0;
  int          m_cnt = 0;

  logic [7:0] req_q[$];
  exp_t       exp_q[$];

  // Monitor: checks each request address, address stability, and the
  // decoded result whenever fetch_busy falls.
  initial begin
    logic       busy_prev;
    logic       tracking;
    logic [7:0] cur_addr;
    exp_t       e;
    busy_prev = 1'b0;
    tracking  = 1'b0;
    cur_addr  = 8'd0;
    forever begin
      @(negedge clock);
      if (imem_req) begin
        if (req_q.size() == 0) flag("unexpected_imem_req");
        else begin
          cur_addr = req_q.pop_front();
          check("imem_addr", 32'(imem_addr), 32'(cur_addr));
          tracking = 1'b1;
        end
      end else if (tracking && fetch_busy) begin
        check("imem_addr_stable", 32'(imem_addr), 32'(cur_addr));
      end
      if (busy_prev && !fetch_busy) begin
        tracking = 1'b0;
        if (exp_q.size() == 0) flag("unexpected_busy_fall");
        else begin
          e = exp_q.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("opcode", 32'(opcode), 32'(e.ir[15:12]));
          check("rd", 32'(rd), 32'(e.ir[11:8]));
          check("rs1", 32'(rs1), 32'(e.ir[7:4]));
          check("rs2", 32'(rs2), 32'(e.ir[3:0]));
          check("imm", 32'(imm), 32'(e.ir[7:0]));
          check("is_alu", 32'(is_alu_operation), 32'(e.ir[15:12] < 4'd8));
          check("pc_at_done", 32'(pc), 32'(e.pc));
          check("proto_err_at_done", 32'(proto_err), 32'(e.err));
        end
      end
      busy_prev = fetch_busy;
    end
  end

  task automatic model_reset();
    m_pc = 8'd0; m_ir = 16'd0; m_err = 1'b0; m_halted = 1'b0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; fetch_ = 1'b0; next_ = 1'b0; halt_ = 1'b0; imem_valid = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  // mode: 0 normal, 1 reset in second WAIT cycle (late data follows), 2 halt there
  task automatic do_fetch(input logic [15:0] data, input int lat, input bit spur,
                          input bit ef, input bit en, input int mode);
    exp_t e;
    int   tf;
    @(posedge clock); #1;
    fetch_ = 1'b1;
    tf = cyc;
    req_q.push_back(m_pc);
    @(negedge clock);
    check("busy_on_fetch", 32'(fetch_busy), 32'd1);
    @(posedge clock); #1;                      // REQ cycle
    fetch_ = 1'b0;
    if (spur) begin imem_valid = 1'b1; imem_rdata = 16'($urandom); end
    for (int k = 1; k <= lat; k++) begin
      @(posedge clock); #1;                    // WAIT cycle k
      fetch_ = 1'b0; next_ = 1'b0; imem_valid = 1'b0; imem_rdata = 16'($urandom);
      if (k == 1 && ef) fetch_ = 1'b1;
      if (k == 1 && en) begin next_ = 1'b1; branch_cond = 1'($urandom); end
      if (k == 1 && (ef || en)) m_err = 1'b1;
      if (mode != 0 && k == 2) begin
        if (mode == 1) begin
          reset_n = 1'b0;
          model_reset();
          e.ir = 16'd0; e.pc = 8'd0; e.err = 1'b0; e.cyc = cyc + 1;
          exp_q.push_back(e);
          @(posedge clock); #1;
          reset_n = 1'b1;
          imem_valid = 1'b1; imem_rdata = data;  // late data, must be ignored
          @(posedge clock); #1;
          imem_valid = 1'b0;
        end else begin
          halt_ = 1'b1;
          m_halted = 1'b1;
          e.ir = m_ir; e.pc = m_pc; e.err = m_err; e.cyc = cyc + 1;
          exp_q.push_back(e);
          @(posedge clock); #1;
          halt_ = 1'b0;
        end
        return;
      end
      if (k == lat) begin imem_valid = 1'b1; imem_rdata = data; end
    end
    m_ir = data;
    e.ir = data; e.pc = m_pc; e.err = m_err; e.cyc = tf + 2 + lat;
    exp_q.push_back(e);
    @(posedge clock); #1;
    imem_valid = 1'b0; fetch_ = 1'b0; next_ = 1'b0;
  endtask

  task automatic do_next(input bit cond, input bit with_fetch);
    int off;
    @(posedge clock); #1;
    next_ = 1'b1; branch_cond = cond; fetch_ = with_fetch;
    if (with_fetch) m_err = 1'b1;
    else if (!m_halted) begin
      off = {28'd0, m_ir[11:8]};
      if (off >= 8) off = off - 16;
      if ((m_ir[15:12] == 4'd12 && cond) || (m_ir[15:12] == 4'd13 && !cond))
        m_pc = 8'((int'(m_pc) + off + 256) % 256);
      else
        m_pc = 8'((int'(m_pc) + 1) % 256);
      m_cnt++;
    end
    @(posedge clock); #1;
    next_ = 1'b0; fetch_ = 1'b0;
    @(negedge clock);
    check("pc_after_next", 32'(pc), 32'(m_pc));
    check("proto_err_after_next", 32'(proto_err), 32'(m_err));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 3))
      0: w[15:12] = 4'd12;
      1: w[15:12] = 4'd13;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    do_reset();
    @(negedge clock);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_opcode", 32'(opcode), 32'd0);
    check("rst_fields", 32'({rd, rs1, rs2}), 32'd0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    check("rst_err", 32'(proto_err), 32'd0);

    do_fetch(16'h3A45, 1, 1'b0, 1'b0, 1'b0, 0);
    do_fetch(16'h7123, 5, 1'b1, 1'b0, 1'b0, 0);
    repeat (10) do_next(1'b0, 1'b0);            // pc -> 10
    do_fetch(16'hC312, 2, 1'b0, 1'b0, 1'b0, 0);
    do_next(1'b1, 1'b0);                        // BEQ taken, +3
    do_fetch(16'hCE00, 1, 1'b0, 1'b0, 1'b0, 0);
    do_next(1'b1, 1'b0);                        // BEQ taken, -2
    do_fetch(16'hD300, 1, 1'b0, 1'b0, 1'b0, 0);
    do_next(1'b1, 1'b0);                        // BNE not taken, +1

    do_reset();
    do_fetch(16'hCF00, 1, 1'b0, 1'b0, 1'b0, 0);
    do_next(1'b1, 1'b0);                        // 0 - 1 -> 255
    do_fetch(16'h1000, 1, 1'b0, 1'b0, 1'b0, 0);
    do_next(1'b0, 1'b0);                        // 255 + 1 -> 0

    do_reset();
    do_fetch(16'h2345, 4, 1'b0, 1'b1, 1'b1, 0); // strobes during WAIT
    do_fetch(16'h5555, 4, 1'b0, 1'b0, 1'b0, 1); // reset mid-WAIT, late data
    @(negedge clock);
    check("ir_after_late_valid", 32'({opcode, rd, rs1, rs2}), 32'd0);

    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 3) do_next(1'($urandom), 1'b0);
      else if (r == 4) do_next(1'($urandom), 1'b1);
      else do_fetch(rand_instr(), $urandom_range(1, 6), 1'($urandom),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), 0);
    end
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    @(negedge clock);
    check("retired_count", 32'(retired_count), 32'(m_cnt));
`endif

    do_reset();
    do_fetch(16'h0111, 1, 1'b0, 1'b0, 1'b0, 0);
    repeat (3) do_next(1'($urandom), 1'b0);
    do_fetch(16'h4444, 5, 1'b0, 1'b0, 1'b0, 2); // halt in WAIT
    @(negedge clock);
    check("halted_busy", 32'(fetch_busy), 32'd0);
    check("halted_err_before", 32'(proto_err), 32'd0);
    @(posedge clock); #1;
    fetch_ = 1'b1;
    @(negedge clock);
    check("halted_fetch_busy", 32'(fetch_busy), 32'd0);
    @(posedge clock); #1;
    fetch_ = 1'b0;
    m_err = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("halted_fetch_err", 32'(proto_err), 32'(m_err));
    do_next(1'b0, 1'b0);                        // ignored in HALTED
`ifdef FETCH_DECODE_INSTR_COUNT_EN
    check("retired_count_frozen", 32'(retired_count), 32'(m_cnt));
`endif
    repeat (3) @(posedge clock);
    check("req_q_drained", 32'(req_q.size()), 32'd0);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
